// File: rtl/lfsr_prng.sv
// lfsr_prng -- seedable Fibonacci LFSR pseudo-random number generator.
//
// A one-cycle seed_valid strobe loads the seed and starts generation. From
// the next clock on, one new word is produced on every edge, flagged by
// random_number_valid. Generation continues until rst or another seed load.
// There is no backpressure, so a consumer must capture every valid cycle.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset (state -> 0, idle)
//   seed_in              seed value, sampled only when seed_valid=1
//   seed_valid           seed load strobe; takes priority over advancing
//   random_number        current LFSR state (registered)
//   random_number_valid  high when random_number holds a freshly advanced word
module lfsr_prng #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] TAPS       = 16'hB400,
  parameter logic [DATA_WIDTH-1:0] ZERO_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] seed_in,
  input  logic                  seed_valid,
  output logic [DATA_WIDTH-1:0] random_number,
  output logic                  random_number_valid
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic [DATA_WIDTH-1:0] state;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  running;
  logic                  valid;
  logic                  fb;

  // The all-zero state would lock the LFSR, so a zero seed is replaced.
  assign load_value = (seed_in == '0) ? ZERO_SEED : seed_in;

  // Fibonacci feedback: parity of the tapped state bits.
  assign fb = ^(state & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= '0;
      running <= IDLE;
      valid   <= 1'b0;
    end else if (seed_valid) begin
      // A load never produces a valid word; the first one follows next edge.
      state   <= load_value;
      running <= RUN;
      valid   <= 1'b0;
    end else if (running == RUN) begin
      state   <= {state[DATA_WIDTH-2:0], fb};
      valid   <= 1'b1;
    end else begin
      valid   <= 1'b0;
    end
  end

  assign random_number       = state;
  assign random_number_valid = valid;

endmodule

// File: tb/tb_lfsr_prng.sv
module tb_lfsr_prng;

  localparam logic [15:0] TAPS      = 16'hB400;
  localparam logic [15:0] ZERO_SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] seed_in = '0;
  logic        seed_valid = 1'b0;
  logic [15:0] random_number;
  logic        random_number_valid;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  lfsr_prng dut (
    .clk                 (clk),
    .rst                 (rst),
    .seed_in             (seed_in),
    .seed_valid          (seed_valid),
    .random_number       (random_number),
    .random_number_valid (random_number_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [15:0] seed;
    logic [15:0] exp_rn;
    logic        exp_vld;
  } vec_t;

  vec_t vecs[$];

  // Reference next word: shift left by one (multiply by two, mod 2^16) and
  // append the parity of the number of tapped bits that are set.
  function automatic logic [15:0] ref_next(logic [15:0] s);
    int fb;
    int v;
    fb = $countones(s & TAPS) % 2;
    v  = (int'(s) * 2 + fb) % 65536;
    return v[15:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tot_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic sv, logic [15:0] seed, logic [15:0] rn, logic vld);
    vec_t v;
    v.sv = sv; v.seed = seed; v.exp_rn = rn; v.exp_vld = vld;
    vecs.push_back(v);
  endtask

  logic [15:0] m_st;
  logic        m_run;
  logic        m_vld;

  initial begin
    // ---------------- vector table ----------------
    add(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    add(1'b0, 16'h0000, 16'hFFFE, 1'b1);
    add(1'b0, 16'h0000, 16'hFFFC, 1'b1);
    add(1'b0, 16'h0000, 16'hFFF8, 1'b1);
    add(1'b0, 16'h0000, 16'hFFF0, 1'b1);
    add(1'b0, 16'h0000, 16'hFFE0, 1'b1);
    add(1'b0, 16'h0000, 16'hFFC0, 1'b1);
    add(1'b0, 16'h0000, 16'hFF80, 1'b1);
    add(1'b0, 16'h0000, 16'hFF00, 1'b1);
    add(1'b0, 16'h0000, 16'hFE00, 1'b1);
    add(1'b0, 16'h0000, 16'hFC00, 1'b1);
    add(1'b0, 16'h0000, 16'hF800, 1'b1);
    add(1'b0, 16'h0000, 16'hF001, 1'b1);
    // reseed mid-run
    add(1'b1, 16'h0001, 16'h0001, 1'b0);
    add(1'b0, 16'h0000, 16'h0002, 1'b1);
    add(1'b0, 16'h0000, 16'h0004, 1'b1);
    add(1'b0, 16'h0000, 16'h0008, 1'b1);
    // zero seed mid-run
    add(1'b1, 16'h0000, 16'hACE1, 1'b0);
    add(1'b0, 16'h0000, 16'h59C3, 1'b1);
    // seed held for three edges
    add(1'b1, 16'h1234, 16'h1234, 1'b0);
    add(1'b1, 16'h1234, 16'h1234, 1'b0);
    add(1'b1, 16'h1234, 16'h1234, 1'b0);
    add(1'b0, 16'h0000, 16'h2469, 1'b1);
    add(1'b0, 16'h0000, 16'h48D2, 1'b1);

    // ---------------- reset check ----------------
    #2;
    rst = 1'b1;
    #1;
    chk("reset_rn", 32'(random_number), 32'h0);
    chk("reset_vld", 32'(random_number_valid), 32'h0);
    step();
    step();
    rst = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (random_number !== 16'h0 || random_number_valid !== 1'b0) bad++;
      end
      chk("idle_after_reset", 32'(bad), 32'h0);
    end

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      seed_valid = vecs[i].sv;
      seed_in    = vecs[i].seed;
      step();
      chk($sformatf("vec%0d_rn", i), 32'(random_number), 32'(vecs[i].exp_rn));
      chk($sformatf("vec%0d_vld", i), 32'(random_number_valid), 32'(vecs[i].exp_vld));
    end
    seed_valid = 1'b0;

    // ---------------- reset mid-run ----------------
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_reset_rn", 32'(random_number), 32'h0);
    chk("midrun_reset_vld", 32'(random_number_valid), 32'h0);
    step();
    rst = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (random_number !== 16'h0 || random_number_valid !== 1'b0) bad++;
      end
      chk("no_gen_after_reset", 32'(bad), 32'h0);
    end

    // zero seed from IDLE
    seed_valid = 1'b1;
    seed_in    = 16'h0000;
    step();
    seed_valid = 1'b0;
    chk("idle_zero_seed_rn", 32'(random_number), 32'(ZERO_SEED));
    chk("idle_zero_seed_vld", 32'(random_number_valid), 32'h0);
    step();
    chk("idle_zero_next_rn", 32'(random_number), 32'h59C3);
    chk("idle_zero_next_vld", 32'(random_number_valid), 32'h1);

    // ---------------- randomized against model ----------------
    m_st  = 16'h59C3;
    m_run = 1'b1;
    m_vld = 1'b1;
    begin
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
        seed_valid = ($urandom_range(0, 7) == 0);
        seed_in    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        if (seed_valid) begin
          m_st  = (seed_in == 16'h0) ? ZERO_SEED : seed_in;
          m_run = 1'b1;
          m_vld = 1'b0;
        end else if (m_run) begin
          m_st  = ref_next(m_st);
          m_vld = 1'b1;
        end else begin
          m_vld = 1'b0;
        end
        step();
        if (random_number !== m_st || random_number_valid !== m_vld) begin
          if (bad < 5)
            $display("FAIL random_cycle%0d: got %h/%b expected %h/%b",
                     i, random_number, random_number_valid, m_st, m_vld);
          bad++;
        end
      end
      chk("random_mismatches", 32'(bad), 32'h0);
    end

    // ---------------- period check ----------------
    seed_valid = 1'b1;
    seed_in    = 16'h0001;
    step();
    seed_valid = 1'b0;
    chk("period_seed_rn", 32'(random_number), 32'h0001);
    begin
      int first_ret = -1;
      int zeros = 0;
      int bad = 0;
      int nvld = 0;
      m_st = 16'h0001;
      for (int i = 1; i <= 65535; i++) begin
        step();
        m_st = ref_next(m_st);
        if (random_number !== m_st) bad++;
        if (random_number_valid !== 1'b1) nvld++;
        if (random_number == 16'h0) zeros++;
        if (random_number == 16'h0001 && first_ret < 0) first_ret = i;
      end
      chk("period_model_mismatch", 32'(bad), 32'h0);
      chk("period_valid_drops", 32'(nvld), 32'h0);
      chk("period_zero_seen", 32'(zeros), 32'h0);
      chk("period_first_return", 32'(first_ret), 32'd65535);
      step();
      chk("period_wrap_next", 32'(random_number), 32'h0002);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
